// File: rtl/anahtar_geri_olusturma.sv
// Iterative AES-128 inverse key schedule: walks from round key TUR_SAYISI back to the cipher key.
// Optional key store enabled by defining ANAHTAR_BELLEK_EN.

module Bit_Degisikligi (
    input  logic [31:0] giris_i,
    output logic [31:0] cikis_o
);

    function automatic logic [7:0] gf_carp(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        logic [7:0] t;
        s = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) s = s ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return s;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_ters(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_carp(p, p);
            r = gf_carp(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_ters(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        cikis_o = {sbox(giris_i[31:24]), sbox(giris_i[23:16]), sbox(giris_i[15:8]), sbox(giris_i[7:0])};
    end

endmodule

module anahtar_geri_olusturma #(
    parameter int unsigned TUR_SAYISI = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         basla,
    input  logic [127:0] son_anahtar,
    output logic         hazir,
    output logic         cikis_gecerli,
    input  logic         cikis_hazir,
    output logic [127:0] anahtar_cikis,
    output logic [3:0]   cikis_tur,
    output logic         bitti,
    input  logic [3:0]   oku_tur,
    output logic [127:0] oku_anahtar
);

    typedef enum logic {BOS, CALIS} durum_t;

    localparam logic [3:0] TUR_BASLANGIC = 4'(TUR_SAYISI);

    durum_t       durum_q;
    logic         hazir_q;
    logic         gecerli_q;
    logic         bitti_q;
    logic [127:0] anahtar_q;
    logic [3:0]   tur_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  sub_w;
    logic [3:0]   tur_eksi;
    logic [127:0] onceki_d;
    logic         aktarim;

    function automatic logic [7:0] rcon(input logic [3:0] k);
        case (k)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w0 = anahtar_q[127:96];
    assign w1 = anahtar_q[95:64];
    assign w2 = anahtar_q[63:32];
    assign w3 = anahtar_q[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign tur_eksi = tur_q - 4'd1;

    Bit_Degisikligi u_sbox (
        .giris_i (p3),
        .cikis_o (sub_w)
    );

    // Rotating after substitution equals the forward SubWord(RotWord()) order.
    always_comb begin
        onceki_d = {w0 ^ {sub_w[23:0], sub_w[31:24]} ^ {rcon(tur_eksi), 24'h0}, p1, p2, p3};
    end

    assign aktarim = gecerli_q & cikis_hazir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q   <= BOS;
            hazir_q   <= 1'b1;
            gecerli_q <= 1'b0;
            bitti_q   <= 1'b0;
            anahtar_q <= '0;
            tur_q     <= '0;
        end else begin
            bitti_q <= 1'b0;
            case (durum_q)
                BOS: begin
                    if (basla) begin
                        anahtar_q <= son_anahtar;
                        tur_q     <= TUR_BASLANGIC;
                        gecerli_q <= 1'b1;
                        hazir_q   <= 1'b0;
                        durum_q   <= CALIS;
                    end
                end
                CALIS: begin
                    if (aktarim) begin
                        if (tur_q != '0) begin
                            anahtar_q <= onceki_d;
                            tur_q     <= tur_eksi;
                        end else begin
                            gecerli_q <= 1'b0;
                            bitti_q   <= 1'b1;
                            hazir_q   <= 1'b1;
                            durum_q   <= BOS;
                        end
                    end
                end
            endcase
        end
    end

    assign hazir         = hazir_q;
    assign cikis_gecerli = gecerli_q;
    assign anahtar_cikis = anahtar_q;
    assign cikis_tur     = tur_q;
    assign bitti         = bitti_q;

`ifdef ANAHTAR_BELLEK_EN
    logic [127:0] bellek_q [11];
    logic [127:0] oku_q;

    // Deliberately unreset: entries survive rst and are only overwritten by later runs.
    always_ff @(posedge clk) begin
        if (aktarim && tur_q <= 4'd10) bellek_q[tur_q] <= anahtar_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) oku_q <= '0;
        else     oku_q <= (oku_tur <= 4'd10) ? bellek_q[oku_tur] : '0;
    end

    assign oku_anahtar = oku_q;
`else
    logic unused_oku;
    assign unused_oku  = ^oku_tur;
    assign oku_anahtar = '0;
`endif

endmodule

// File: tb/tb_anahtar_geri_olusturma.sv
// Scoreboard bench for anahtar_geri_olusturma: expected round keys come from a forward
// AES-128 key expansion of a cipher key; a monitor pops and compares every transferred beat.

module tb_anahtar_geri_olusturma;

    typedef struct {
        logic [3:0]   tur;
        logic [127:0] key;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         basla0, h0, hz0, g0, bitti0;
    logic [127:0] son0, key0, oku_a0;
    logic [3:0]   tur0, oku0;

    logic         basla1, h1, hz1, g1, bitti1;
    logic [127:0] son1, key1, oku_a1;
    logic [3:0]   tur1, oku1;

    int total = 0;
    int bad   = 0;

    beat_t        q0[$];
    beat_t        q1[$];
    logic [127:0] got0 [16];
    logic [7:0]   sbox_t [256];
    logic [127:0] rk [11];

    anahtar_geri_olusturma dut (
        .clk(clk), .rst(rst), .basla(basla0), .son_anahtar(son0), .hazir(hz0),
        .cikis_gecerli(g0), .cikis_hazir(h0), .anahtar_cikis(key0), .cikis_tur(tur0),
        .bitti(bitti0), .oku_tur(oku0), .oku_anahtar(oku_a0)
    );

    anahtar_geri_olusturma #(.TUR_SAYISI(1)) dut1 (
        .clk(clk), .rst(rst), .basla(basla1), .son_anahtar(son1), .hazir(hz1),
        .cikis_gecerli(g1), .cikis_hazir(h1), .anahtar_cikis(key1), .cikis_tur(tur1),
        .bitti(bitti1), .oku_tur(oku1), .oku_anahtar(oku_a1)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box built by walking generator 3 and its inverse together.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4) ^ 8'h63;
            sbox_t[p] = x;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor for the default instance, including hold-stable checks under backpressure.
    logic         stall_prev = 1'b0;
    logic [127:0] key_prev;
    logic [3:0]   tur_prev;
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && g0) begin
                chk("hold_key", key0, key_prev);
                chk("hold_tur", 128'(tur0), 128'(tur_prev));
            end
            if (g0 && h0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_beat", 128'(tur0), 128'hx);
                end else begin
                    b = q0.pop_front();
                    chk("beat_tur", 128'(tur0), 128'(b.tur));
                    chk("beat_key", key0, b.key);
                    got0[tur0] = key0;
                end
            end
            stall_prev = g0 && !h0;
            key_prev   = key0;
            tur_prev   = tur0;
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (!rst && g1 && h1) begin
            if (q1.size() == 0) begin
                chk("unexpected_beat1", 128'(tur1), 128'hx);
            end else begin
                b = q1.pop_front();
                chk("beat1_tur", 128'(tur1), 128'(b.tur));
                chk("beat1_key", key1, b.key);
            end
        end
    end

    task automatic wait_idle0();
        for (int i = 0; i < 50 && !hz0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("hazir_idle", 128'(hz0), 128'd1);
    endtask

    task automatic start0(input logic [127:0] ck);
        expand(ck);
        for (int r = 10; r >= 0; r--) q0.push_back('{tur: 4'(r), key: rk[r]});
        wait_idle0();
        basla0 = 1'b1;
        son0   = rk[10];
        @(posedge clk);
        #1;
        basla0 = 1'b0;
        son0   = rand128();
    endtask

    // mode 0: consumer always ready (except the optional 3-cycle hold); mode 1: random ready.
    task automatic run0(input logic [127:0] ck, input int mode, input int hold_at, input bit glitch);
        int edges;
        int held;
        bit seen;
        start0(ck);
        edges = 0;
        held  = 0;
        seen  = 0;
        while (!seen && edges < 300) begin
            if (mode == 1) h0 = ($urandom_range(0, 3) != 0);
            else if (g0 && tur0 == hold_at && held < 3) begin
                h0 = 1'b0;
                held++;
            end else h0 = 1'b1;
            if (glitch && edges == 4) begin
                basla0 = 1'b1;
                chk("hazir_busy", 128'(hz0), 128'd0);
            end else basla0 = 1'b0;
            @(posedge clk);
            #1;
            edges++;
            if (bitti0) seen = 1;
        end
        basla0 = 1'b0;
        h0     = 1'b1;
        chk("bitti_seen", 128'(seen), 128'd1);
        if (mode == 0) chk("bitti_latency", 128'(edges), 128'(11 + (hold_at >= 0 ? 3 : 0)));
        chk("hazir_at_bitti", 128'(hz0), 128'd1);
        chk("gecerli_at_bitti", 128'(g0), 128'd0);
        @(posedge clk);
        #1;
        chk("bitti_pulse", 128'(bitti0), 128'd0);
        chk("queue_drained", 128'(q0.size()), 128'd0);
    endtask

    task automatic reset_mid(input logic [127:0] ck);
        int n;
        start0(ck);
        h0 = 1'b1;
        n = 0;
        while (!(g0 && tur0 == 4'd6) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_tur6", 128'(tur0), 128'd6);
        #2 rst = 1'b1;
        #1;
        chk("rst_hazir", 128'(hz0), 128'd1);
        chk("rst_gecerli", 128'(g0), 128'd0);
        chk("rst_key", key0, 128'd0);
        chk("rst_tur", 128'(tur0), 128'd0);
        chk("rst_bitti", 128'(bitti0), 128'd0);
        chk("rst_oku", oku_a0, 128'd0);
        q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run1(input logic [127:0] ck);
        int edges;
        bit seen;
        expand(ck);
        q1.push_back('{tur: 4'd1, key: rk[1]});
        q1.push_back('{tur: 4'd0, key: rk[0]});
        chk("hazir1_idle", 128'(hz1), 128'd1);
        basla1 = 1'b1;
        son1   = rk[1];
        @(posedge clk);
        #1;
        basla1 = 1'b0;
        edges  = 0;
        seen   = 0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (bitti1) seen = 1;
        end
        chk("bitti1_latency", 128'(edges), 128'd2);
        chk("queue1_drained", 128'(q1.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        build_sbox();
        rst    = 1'b1;
        basla0 = 1'b0; son0 = '0; h0 = 1'b1; oku0 = '0;
        basla1 = 1'b0; son1 = '0; h1 = 1'b1; oku1 = '0;
        #1;
        chk("init_hazir", 128'(hz0), 128'd1);
        chk("init_gecerli", 128'(g0), 128'd0);
        chk("init_key", key0, 128'd0);
        chk("init_tur", 128'(tur0), 128'd0);
        chk("init_bitti", 128'(bitti0), 128'd0);
        chk("init_oku", oku_a0, 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run0(FIPS_KEY, 0, -1, 1'b0);
        chk("fips_tur10", got0[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_tur9",  got0[9],  128'hac7766f319fadc2128d12941575c006e);
        chk("fips_tur1",  got0[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_tur0",  got0[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

`ifdef ANAHTAR_BELLEK_EN
        oku0 = 4'd0;
        @(posedge clk);
        #1;
        chk("store_tur0", oku_a0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        oku0 = 4'd10;
        @(posedge clk);
        #1;
        chk("store_tur10", oku_a0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        oku0 = 4'd12;
        @(posedge clk);
        #1;
        chk("store_oob", oku_a0, 128'd0);
`else
        for (int i = 0; i < 3; i++) begin
            oku0 = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            chk("no_store", oku_a0, 128'd0);
        end
`endif

        run0(FIPS_KEY, 0, 5, 1'b0);
        run0(FIPS_KEY, 0, -1, 1'b1);
        reset_mid(rand128());
        run0(rand128(), 0, -1, 1'b0);
        for (int i = 0; i < 6; i++) run0(rand128(), 1, -1, 1'(i % 2));

        run1(FIPS_KEY);
        for (int i = 0; i < 3; i++) run1(rand128());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
